// File: rtl/hdb3_pkg.sv
// hdb3_pkg: constants and types shared by the HDB3 test-pattern generator and checker.
package hdb3_pkg;
    localparam logic [31:0] TEST_PATTERN = 32'hB00C_200B;
    localparam int CNT_W  = 32;
    localparam int SLIP_W = 8;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/hdb3_pat_rot_match.sv
// hdb3_pat_rot_match: compares a 32-bit window against all 32 rotations of the pattern.
module hdb3_pat_rot_match
    import hdb3_pkg::*;
#(
    parameter logic [31:0] PATTERN = TEST_PATTERN
) (
    input  logic [31:0] w,
    output logic        hit,
    output logic [4:0]  k
);
    logic [31:0] match;
    for (genvar i = 0; i < 32; i++) begin : g_rot
        localparam logic [63:0] PP = {PATTERN, PATTERN} << i;
        assign match[i] = (w == PP[63:32]);
    end
    // rotations are distinct, so at most one bit of match is set and OR-ing indices is exact
    always_comb begin
        k = 5'd0;
        for (int j = 0; j < 32; j++) k = k | (match[j] ? 5'(j) : 5'd0);
    end
    assign hit = |match;
endmodule

// File: rtl/hdb3_pattern_checker.sv
// hdb3_pattern_checker: aligns to the cyclic HDB3 test pattern, then counts checked bits,
// bit errors and pattern slips.
module hdb3_pattern_checker
    import hdb3_pkg::*;
#(
    parameter logic [31:0] PATTERN     = TEST_PATTERN,
    parameter int          VERIFY_LEN  = 32,
    parameter int          LOSS_WIN    = 64,
    parameter int          LOSS_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    input  logic              data_valid,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  bit_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [SLIP_W-1:0] slip_count
);
    localparam int RUN_W = $clog2(VERIFY_LEN + 1);
    localparam int WIN_W = $clog2(LOSS_WIN + 1);
    localparam int ERR_W = $clog2(LOSS_THRESH + 1);

    state_t           state, state_nx;
    logic [31:0]      w, w_nx;
    logic [5:0]       fill;
    logic [4:0]       idx, k;
    logic [RUN_W-1:0] run;
    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] win_err, win_err_nx;
    logic             hit, bad, go_verify, err_hit, slip, win_end;

    assign w_nx = {w[30:0], data_in};
    assign bad  = data_in != PATTERN[idx];

    hdb3_pat_rot_match #(.PATTERN(PATTERN)) u_match (
        .w   (w_nx),
        .hit (hit),
        .k   (k)
    );

    always_comb begin
        state_nx   = state;
        go_verify  = data_valid && state == HUNT && fill >= 6'd31 && hit;
        err_hit    = data_valid && state == LOCKED && bad;
        win_err_nx = win_err + ERR_W'(err_hit);
        slip       = err_hit && win_err_nx == ERR_W'(LOSS_THRESH);
        win_end    = win_cnt == WIN_W'(LOSS_WIN - 1);
        if (data_valid)
            case (state)
                HUNT:    state_nx = go_verify ? VERIFY : HUNT;
                VERIFY:  state_nx = bad ? HUNT : (run == RUN_W'(VERIFY_LEN - 1)) ? LOCKED : VERIFY;
                LOCKED:  state_nx = slip ? HUNT : LOCKED;
                default: state_nx = HUNT;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nx;
    end

    // fill is held at zero outside HUNT, so every return to HUNT restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w         <= '0;
            fill      <= '0;
            idx       <= '0;
            run       <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_hit;
            if (data_valid) begin
                w       <= w_nx;
                fill    <= (state != HUNT) ? 6'd0 : (fill == 6'd32) ? fill : fill + 6'd1;
                idx     <= go_verify ? 5'd31 - k : (state != HUNT) ? idx - 5'd1 : idx;
                run     <= (state == VERIFY && !bad) ? run + RUN_W'(1) : '0;
                win_cnt <= (state != LOCKED || win_end) ? '0 : win_cnt + WIN_W'(1);
                win_err <= (state != LOCKED || win_end) ? '0 : win_err_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count  <= '0;
            err_count  <= '0;
            slip_count <= '0;
        end else begin
            bit_count  <= clear ? '0 : bit_count + CNT_W'(data_valid && state == LOCKED && ~&bit_count);
            err_count  <= clear ? '0 : err_count + CNT_W'(err_hit && ~&err_count);
            slip_count <= clear ? '0 : slip_count + SLIP_W'(slip && ~&slip_count);
        end
    end

    assign locked = state == LOCKED;
endmodule

// File: tb/tb_hdb3_pattern_checker.sv
// tb_hdb3_pattern_checker: scenario tasks for the HDB3 pattern checker with a queue-based
// scoreboard of expected outputs per clock.
module tb_hdb3_pattern_checker;
    localparam logic [31:0] PAT = 32'hB00C_200B;
    localparam int VLEN = 32, LWIN = 64, LTH = 4;

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [31:0] bc;
        logic [31:0] ec;
        logic [7:0]  sc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, data_in = 1'b0, data_valid = 1'b0, clear = 1'b0;
    logic        locked, err_pulse;
    logic [31:0] bit_count, err_count;
    logic [7:0]  slip_count;

    int vectors = 0, miscompares = 0, gen_pos = 27;
    exp_t sb[$];
    exp_t got_e;

    int          m_st, m_fill, m_run, m_wc, m_we;
    logic [31:0] m_w, m_bc, m_ec;
    logic [7:0]  m_sc;
    logic [4:0]  m_idx;
    logic        m_ep;

    hdb3_pattern_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .bit_count  (bit_count),
        .err_count  (err_count),
        .slip_count (slip_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, bit_count, err_count, slip_count} !== got_e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got lk=%0b ep=%0b bc=%0d ec=%0d sc=%0d want lk=%0b ep=%0b bc=%0d ec=%0d sc=%0d",
                         $time, locked, err_pulse, bit_count, err_count, slip_count,
                         got_e.lk, got_e.ep, got_e.bc, got_e.ec, got_e.sc);
            end
        end
    end

    function automatic logic [31:0] rot(input int k);
        for (int i = 0; i < 32; i++) rot[i] = PAT[(i - k + 32) % 32];
    endfunction

    function automatic logic gen_bit();
        gen_bit = PAT[31 - gen_pos];
        gen_pos = (gen_pos + 1) % 32;
    endfunction

    task automatic model_reset;
        m_st = 0; m_fill = 0; m_run = 0; m_wc = 0; m_we = 0;
        m_w = '0; m_bc = '0; m_ec = '0; m_sc = '0; m_idx = '0; m_ep = 1'b0;
    endtask

    task automatic step(input logic d, input logic v, input logic c = 1'b0);
        logic [31:0] nw;
        logic        eb;
        @(negedge clk);
        data_in = d; data_valid = v; clear = c;
        m_ep = 1'b0;
        if (v) begin
            nw = {m_w[30:0], d};
            eb = PAT[m_idx];
            if (m_st == 0) begin
                if (m_fill >= 31)
                    for (int k = 0; k < 32; k++)
                        if (nw == rot(k)) begin m_st = 1; m_idx = 5'(31 - k); m_run = 0; end
                if (m_fill < 32) m_fill++;
            end else begin
                m_idx = m_idx - 5'd1;
                if (m_st == 1) begin
                    if (d != eb) begin m_st = 0; m_fill = 0; end
                    else begin
                        m_run++;
                        if (m_run == VLEN) begin m_st = 2; m_wc = 0; m_we = 0; end
                    end
                end else begin
                    if (m_bc != 32'hFFFF_FFFF) m_bc++;
                    if (d != eb) begin
                        if (m_ec != 32'hFFFF_FFFF) m_ec++;
                        m_ep = 1'b1;
                        m_we++;
                    end
                    m_wc++;
                    if (m_we == LTH) begin
                        m_st = 0; m_fill = 0;
                        if (m_sc != 8'hFF) m_sc++;
                    end else if (m_wc == LWIN) begin m_wc = 0; m_we = 0; end
                end
            end
            m_w = nw;
        end
        if (c) begin m_bc = '0; m_ec = '0; m_sc = '0; end
        sb.push_back('{m_st == 2, m_ep, m_bc, m_ec, m_sc});
        @(posedge clk); #1;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(gen_bit(), 1'b1);
    endtask

    task automatic bad_bit(input logic c = 1'b0);
        step(~gen_bit(), 1'b1, c);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; data_in = 1'b0; data_valid = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reset_and_lock;
        do_reset();
        clean(64);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL relock locked=%0b want 1", locked); end
    endtask

    task automatic test_reset;
        do_reset();
        vectors++;
        if ({locked, err_pulse, bit_count, err_count, slip_count} !== 74'd0) begin
            miscompares++;
            $display("FAIL reset_state lk=%0b ep=%0b bc=%0d ec=%0d sc=%0d want all 0",
                     locked, err_pulse, bit_count, err_count, slip_count);
        end
    endtask

    task automatic test_lock;
        do_reset();
        clean(63);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_early locked=%0b want 0", locked); end
        clean(1);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_at_64 locked=%0b want 1", locked); end
        clean(20);
        vectors++;
        if (bit_count !== 32'd20) begin miscompares++; $display("FAIL lock_bits bit_count=%0d want 20", bit_count); end
        vectors++;
        if (err_count !== 32'd0) begin miscompares++; $display("FAIL lock_errs err_count=%0d want 0", err_count); end
    endtask

    task automatic test_back_to_back;
        reset_and_lock();
        clean(5);
        bad_bit();
        vectors++;
        if ({err_pulse, err_count, locked} !== {1'b1, 32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_err ep=%0b ec=%0d lk=%0b want 1 1 1", err_pulse, err_count, locked);
        end
        clean(1);
        vectors++;
        if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL pulse_width ep=%0b want 0", err_pulse); end
        bad_bit();
        bad_bit();
        vectors++;
        if ({err_pulse, err_count} !== {1'b1, 32'd3}) begin
            miscompares++;
            $display("FAIL b2b_err ep=%0b ec=%0d want 1 3", err_pulse, err_count);
        end
        clean(3);
        vectors++;
        if ({locked, bit_count, slip_count} !== {1'b1, 32'd12, 8'd0}) begin
            miscompares++;
            $display("FAIL b2b_after lk=%0b bc=%0d sc=%0d want 1 12 0", locked, bit_count, slip_count);
        end
    endtask

    task automatic test_slip;
        reset_and_lock();
        bad_bit(); clean(1); bad_bit(); clean(1); bad_bit(); clean(1);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL slip_early locked=%0b want 1", locked); end
        bad_bit();
        vectors++;
        if ({locked, slip_count, err_count, bit_count} !== {1'b0, 8'd1, 32'd4, 32'd7}) begin
            miscompares++;
            $display("FAIL slip lk=%0b sc=%0d ec=%0d bc=%0d want 0 1 4 7", locked, slip_count, err_count, bit_count);
        end
        clean(63);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL slip_relock_early locked=%0b want 0", locked); end
        clean(1);
        vectors++;
        if ({locked, slip_count, bit_count} !== {1'b1, 8'd1, 32'd7}) begin
            miscompares++;
            $display("FAIL slip_relock lk=%0b sc=%0d bc=%0d want 1 1 7", locked, slip_count, bit_count);
        end
    endtask

    task automatic test_verify_error;
        do_reset();
        clean(40);
        bad_bit();
        vectors++;
        if ({err_pulse, err_count, bit_count, locked} !== {1'b0, 32'd0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL verify_err ep=%0b ec=%0d bc=%0d lk=%0b want all 0", err_pulse, err_count, bit_count, locked);
        end
        clean(63);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL verify_relock_early locked=%0b want 0", locked); end
        clean(1);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL verify_relock locked=%0b want 1", locked); end
    endtask

    task automatic test_sparse_valid;
        do_reset();
        for (int i = 1; i <= 66; i++) begin
            step(gen_bit(), 1'b1);
            step(1'($urandom), 1'b0);
            step(1'($urandom), 1'b0);
            if (i == 63) begin
                vectors++;
                if (locked !== 1'b0) begin miscompares++; $display("FAIL sparse_early locked=%0b want 0", locked); end
            end
            if (i == 64) begin
                vectors++;
                if (locked !== 1'b1) begin miscompares++; $display("FAIL sparse_lock locked=%0b want 1", locked); end
            end
        end
        vectors++;
        if (bit_count !== 32'd2) begin miscompares++; $display("FAIL sparse_bits bit_count=%0d want 2", bit_count); end
    endtask

    task automatic test_clear;
        reset_and_lock();
        bad_bit(); bad_bit(); bad_bit();
        clean(61);
        vectors++;
        if ({locked, err_count} !== {1'b1, 32'd3}) begin
            miscompares++;
            $display("FAIL clear_pre lk=%0b ec=%0d want 1 3", locked, err_count);
        end
        bad_bit(1'b1);
        vectors++;
        if ({err_count, bit_count, err_pulse, locked} !== {32'd0, 32'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL clear_err ec=%0d bc=%0d ep=%0b lk=%0b want 0 0 1 1", err_count, bit_count, err_pulse, locked);
        end
        clean(1);
        vectors++;
        if (bit_count !== 32'd1) begin miscompares++; $display("FAIL clear_after bit_count=%0d want 1", bit_count); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({locked, err_pulse, bit_count, err_count, slip_count} !== 74'd0) begin
            miscompares++;
            $display("FAIL async_reset lk=%0b ep=%0b bc=%0d ec=%0d sc=%0d want all 0",
                     locked, err_pulse, bit_count, err_count, slip_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_back_to_back();
        test_slip();
        test_verify_error();
        test_sparse_valid();
        test_clear();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
